// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: registers one memory-stage result, aligns and extends
// load data, drives the register-file write port and counts retired instructions.
module wb_commit_stage #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 hold_i,
  input  logic                 flush_i,
  input  logic                 rd_we_i,
  input  logic [REG_AW-1:0]    rd_addr_i,
  input  logic [1:0]           wb_sel_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      pc_plus4_i,
  input  logic [XLEN-1:0]      csr_data_i,
  input  logic [XLEN-1:0]      load_data_i,
  input  logic [2:0]           load_funct3_i,
  input  logic [1:0]           addr_lsb_i,
  output logic                 reg_write_o,
  output logic [REG_AW-1:0]    reg_waddr_o,
  output logic [XLEN-1:0]      reg_wdata_o,
  output logic                 retire_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 load_err_o
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_CSR  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                 valid_r;
  logic                 rd_we_r;
  logic [REG_AW-1:0]    rd_addr_r;
  logic [1:0]           wb_sel_r;
  logic [XLEN-1:0]      raw_r;
  logic [2:0]           funct3_r;
  logic [1:0]           lsb_r;
  logic [INSTRET_W-1:0] instret_r;

  logic                 accept_s;
  logic                 retire_s;
  logic                 write_s;
  logic                 err_s;
  logic [XLEN-1:0]      raw_sel_s;
  logic [XLEN-1:0]      result_s;
  logic [XLEN:0]        load_s;

  // Returns {err, data}: lane selection plus sign/zero extension of a load word.
  function automatic logic [XLEN:0] load_extract(input logic [XLEN-1:0] word,
                                                 input logic [2:0]      funct3,
                                                 input logic [1:0]      lsb);
    logic [7:0]      b;
    logic [15:0]     h;
    logic            err;
    logic [XLEN-1:0] d;
    b   = word[{lsb, 3'b000} +: 8];
    h   = word[{lsb[1], 4'b0000} +: 16];
    err = 1'b0;
    d   = {XLEN{1'b0}};
    case (funct3)
      F3_LB:  d = {{(XLEN-8){b[7]}}, b};
      F3_LBU: d = {{(XLEN-8){1'b0}}, b};
      F3_LH: begin
        if (lsb[0]) err = 1'b1;
        else        d   = {{(XLEN-16){h[15]}}, h};
      end
      F3_LHU: begin
        if (lsb[0]) err = 1'b1;
        else        d   = {{(XLEN-16){1'b0}}, h};
      end
      F3_LW: begin
        if (lsb != 2'b00) err = 1'b1;
        else              d   = word;
      end
      default: err = 1'b1;
    endcase
    return {err, d};
  endfunction

  assign ready_o  = !hold_i;
  assign accept_s = valid_i && !hold_i && !flush_i;
  assign retire_s = valid_r && !hold_i;

  // Pick the raw candidate to capture; load data is aligned after the register.
  always_comb begin
    raw_sel_s = alu_result_i;
    case (wb_sel_i)
      SEL_ALU:  raw_sel_s = alu_result_i;
      SEL_LOAD: raw_sel_s = load_data_i;
      SEL_PC4:  raw_sel_s = pc_plus4_i;
      SEL_CSR:  raw_sel_s = csr_data_i;
      default:  raw_sel_s = alu_result_i;
    endcase
  end

  // Final writeback value and load error from the stage register.
  always_comb begin
    load_s = load_extract(raw_r, funct3_r, lsb_r);
    if (wb_sel_r == SEL_LOAD) begin
      err_s    = load_s[XLEN];
      result_s = load_s[XLEN-1:0];
    end else begin
      err_s    = 1'b0;
      result_s = raw_r;
    end
  end

  assign write_s     = retire_s && rd_we_r && (rd_addr_r != {REG_AW{1'b0}}) && !err_s;
  assign reg_write_o = write_s;
  assign reg_waddr_o = write_s ? rd_addr_r : {REG_AW{1'b0}};
  assign reg_wdata_o = write_s ? result_s : {XLEN{1'b0}};
  assign retire_o    = retire_s;
  assign load_err_o  = retire_s && err_s;
  assign instret_o   = instret_r;

  // Stage register and retired-instruction counter; flush beats hold and accept.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_r   <= 1'b0;
      rd_we_r   <= 1'b0;
      rd_addr_r <= {REG_AW{1'b0}};
      wb_sel_r  <= 2'b00;
      raw_r     <= {XLEN{1'b0}};
      funct3_r  <= 3'b000;
      lsb_r     <= 2'b00;
      instret_r <= {INSTRET_W{1'b0}};
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
      if (flush_i) begin
        valid_r <= 1'b0;
      end else if (hold_i) begin
        valid_r <= valid_r;
      end else begin
        valid_r <= accept_s;
      end
      if (accept_s) begin
        rd_we_r   <= rd_we_i;
        rd_addr_r <= rd_addr_i;
        wb_sel_r  <= wb_sel_i;
        raw_r     <= raw_sel_s;
        funct3_r  <= load_funct3_i;
        lsb_r     <= addr_lsb_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed vector table, hand-written
// hold/flush/reset sequences, and random traffic against a behavioural model.
module tb_wb_commit_stage;

  localparam logic [31:0] ALU_V = 32'h0000_1234;
  localparam logic [31:0] PC4_V = 32'h0000_0104;
  localparam logic [31:0] CSR_V = 32'hC5C5_0001;
  localparam logic [31:0] LD_V  = 32'h80FF_7F01;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i, hold_i, flush_i, rd_we_i;
  logic        ready_o, reg_write_o, retire_o, load_err_o;
  logic [4:0]  rd_addr_i, reg_waddr_o;
  logic [1:0]  wb_sel_i, addr_lsb_i;
  logic [2:0]  load_funct3_i;
  logic [31:0] alu_result_i, pc_plus4_i, csr_data_i, load_data_i, reg_wdata_o;
  logic [63:0] instret_o;

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .hold_i(hold_i), .flush_i(flush_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
    .wb_sel_i(wb_sel_i), .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
    .csr_data_i(csr_data_i), .load_data_i(load_data_i), .load_funct3_i(load_funct3_i),
    .addr_lsb_i(addr_lsb_i), .reg_write_o(reg_write_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .retire_o(retire_o), .instret_o(instret_o),
    .load_err_o(load_err_o)
  );

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] csr;
    logic [31:0] ld;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic        hold;
    logic        flush;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_cnt;
  vec_t vecs[17];
  in_t  idle_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t x);
    valid_i = x.valid; rd_we_i = x.we; rd_addr_i = x.rd; wb_sel_i = x.sel;
    alu_result_i = x.alu; pc_plus4_i = x.pc4; csr_data_i = x.csr; load_data_i = x.ld;
    load_funct3_i = x.f3; addr_lsb_i = x.lsb; hold_i = x.hold; flush_i = x.flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ret, input logic w,
                          input logic [4:0] a, input logic [31:0] d, input logic e);
    chk({tag, "_retire"}, retire_o, ret);
    chk({tag, "_write"}, reg_write_o, w);
    chk({tag, "_waddr"}, reg_waddr_o, a);
    chk({tag, "_wdata"}, reg_wdata_o, d);
    chk({tag, "_lerr"}, load_err_o, e);
  endtask

  function automatic in_t mk_in(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                                input logic [2:0] f3, input logic [1:0] lsb);
    in_t x;
    x = '0;
    x.valid = 1'b1; x.we = we; x.rd = rd; x.sel = sel; x.f3 = f3; x.lsb = lsb;
    x.alu = ALU_V; x.pc4 = PC4_V; x.csr = CSR_V; x.ld = LD_V;
    return x;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                               input logic [2:0] f3, input logic [1:0] lsb, input logic ew,
                               input logic [4:0] ea, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.in = mk_in(we, rd, sel, f3, lsb);
    v.ew = ew; v.ea = ea; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  function automatic in_t alu_op(input logic [4:0] rd, input logic [31:0] val);
    in_t x;
    x = mk_in(1'b1, rd, 2'b00, 3'b000, 2'b00);
    x.alu = val;
    return x;
  endfunction

  // Reference: {err, value} derived from the load rules with shifts and signed casts.
  function automatic logic [32:0] ref_result(input in_t x);
    logic [31:0] sh;
    byte         sb;
    shortint     sh16;
    int          sv;
    if (x.sel == 2'd0) return {1'b0, x.alu};
    if (x.sel == 2'd2) return {1'b0, x.pc4};
    if (x.sel == 2'd3) return {1'b0, x.csr};
    sh = x.ld >> (8 * x.lsb);
    sb = byte'(sh[7:0]);
    sh16 = shortint'(sh[15:0]);
    case (x.f3)
      3'd0: begin sv = int'(sb); return {1'b0, 32'(sv)}; end
      3'd4: return {1'b0, 24'd0, sh[7:0]};
      3'd1: begin
        if (x.lsb % 2 != 0) return {1'b1, 32'd0};
        sv = int'(sh16);
        return {1'b0, 32'(sv)};
      end
      3'd5: begin
        if (x.lsb % 2 != 0) return {1'b1, 32'd0};
        return {1'b0, 16'd0, sh[15:0]};
      end
      3'd2: begin
        if (x.lsb != 2'd0) return {1'b1, 32'd0};
        return {1'b0, x.ld};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  logic        m_valid;
  in_t         m_inst;
  in_t         cur;
  logic        m_ret, m_w, m_e, rst_cur;
  logic [32:0] m_res;

  initial begin
    idle_in = '0;
    // Byte lane 1 of 0x80FF7F01 is 0x7F; lane 2 is 0xFF.
    vecs[0]  = mkv(1'b1, 5'd5,  2'b00, 3'b000, 2'd0, 1'b1, 5'd5,  32'h0000_1234, 1'b0);
    vecs[1]  = mkv(1'b1, 5'd6,  2'b01, 3'b000, 2'd3, 1'b1, 5'd6,  32'hFFFF_FF80, 1'b0);
    vecs[2]  = mkv(1'b1, 5'd7,  2'b01, 3'b100, 2'd1, 1'b1, 5'd7,  32'h0000_007F, 1'b0);
    vecs[3]  = mkv(1'b1, 5'd7,  2'b01, 3'b100, 2'd2, 1'b1, 5'd7,  32'h0000_00FF, 1'b0);
    vecs[4]  = mkv(1'b1, 5'd8,  2'b01, 3'b001, 2'd2, 1'b1, 5'd8,  32'hFFFF_80FF, 1'b0);
    vecs[5]  = mkv(1'b1, 5'd9,  2'b01, 3'b101, 2'd0, 1'b1, 5'd9,  32'h0000_7F01, 1'b0);
    vecs[6]  = mkv(1'b1, 5'd10, 2'b01, 3'b010, 2'd0, 1'b1, 5'd10, 32'h80FF_7F01, 1'b0);
    vecs[7]  = mkv(1'b1, 5'd11, 2'b01, 3'b010, 2'd2, 1'b0, 5'd0,  32'h0,         1'b1);
    vecs[8]  = mkv(1'b1, 5'd12, 2'b01, 3'b001, 2'd1, 1'b0, 5'd0,  32'h0,         1'b1);
    vecs[9]  = mkv(1'b1, 5'd13, 2'b01, 3'b011, 2'd0, 1'b0, 5'd0,  32'h0,         1'b1);
    vecs[10] = mkv(1'b1, 5'd0,  2'b10, 3'b000, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0);
    vecs[11] = mkv(1'b0, 5'd14, 2'b00, 3'b000, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0);
    vecs[12] = mkv(1'b1, 5'd31, 2'b11, 3'b000, 2'd0, 1'b1, 5'd31, 32'hC5C5_0001, 1'b0);
    vecs[13] = mkv(1'b1, 5'd3,  2'b00, 3'b011, 2'd1, 1'b1, 5'd3,  32'h0000_1234, 1'b0);
    vecs[14] = mkv(1'b1, 5'd4,  2'b10, 3'b000, 2'd0, 1'b1, 5'd4,  32'h0000_0104, 1'b0);
    vecs[15] = mkv(1'b1, 5'd2,  2'b01, 3'b101, 2'd1, 1'b0, 5'd0,  32'h0,         1'b1);
    vecs[16] = mkv(1'b1, 5'd1,  2'b01, 3'b000, 2'd0, 1'b1, 5'd1,  32'h0000_0001, 1'b0);

    // Reset state
    rst_ni = 1'b0;
    apply(idle_in);
    step(); step();
    rst_ni = 1'b1;
    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("reset_instret", instret_o, 64'd0);
    chk("reset_ready", ready_o, 1'b1);
    hold_i = 1'b1; #1;
    chk("ready_hold", ready_o, 1'b0);
    hold_i = 1'b0;
    exp_cnt = 64'd0;
    step();

    // Directed vector table, one instruction at a time
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].in);
      step();
      apply(idle_in);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), 1'b1, vecs[i].ew, vecs[i].ea, vecs[i].ed, vecs[i].ee);
      exp_cnt++;
      step();
      chk($sformatf("vec%0d_instret", i), instret_o, exp_cnt);
    end

    // Back-to-back throughput
    apply(alu_op(5'd7, 32'h11));
    step();
    apply(alu_op(5'd8, 32'h22));
    @(negedge clk);
    chk_outs("b2b_a", 1'b1, 1'b1, 5'd7, 32'h11, 1'b0);
    step();
    apply(idle_in);
    @(negedge clk);
    chk_outs("b2b_b", 1'b1, 1'b1, 5'd8, 32'h22, 1'b0);
    exp_cnt += 64'd2;
    step();
    chk("b2b_instret", instret_o, exp_cnt);

    // Hold for 3 cycles with a competing instruction on the input
    apply(alu_op(5'd9, 32'hAA));
    step();
    cur = alu_op(5'd10, 32'hBB);
    cur.hold = 1'b1;
    apply(cur);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_outs($sformatf("hold%0d", k), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk($sformatf("hold%0d_ready", k), ready_o, 1'b0);
      chk($sformatf("hold%0d_instret", k), instret_o, exp_cnt);
      step();
    end
    apply(idle_in);
    @(negedge clk);
    chk_outs("hold_release", 1'b1, 1'b1, 5'd9, 32'hAA, 1'b0);
    exp_cnt++;
    step();
    @(negedge clk);
    chk_outs("hold_after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("hold_instret", instret_o, exp_cnt);

    // Flush together with valid drops the incoming instruction
    step();
    cur = alu_op(5'd11, 32'hCC);
    cur.flush = 1'b1;
    apply(cur);
    step();
    apply(idle_in);
    @(negedge clk);
    chk_outs("flush_in", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_in_instret", instret_o, exp_cnt);

    // Flush while the stage holds an instruction: it still retires this cycle
    step();
    apply(alu_op(5'd12, 32'h33));
    step();
    cur = alu_op(5'd13, 32'h44);
    cur.flush = 1'b1;
    apply(cur);
    @(negedge clk);
    chk_outs("flush_stage", 1'b1, 1'b1, 5'd12, 32'h33, 1'b0);
    exp_cnt++;
    step();
    apply(idle_in);
    @(negedge clk);
    chk_outs("flush_stage_after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_stage_instret", instret_o, exp_cnt);

    // Flush and hold together clear the stage
    step();
    apply(alu_op(5'd14, 32'h55));
    step();
    apply(idle_in);
    hold_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_hold_retire", retire_o, 1'b0);
    step();
    apply(idle_in);
    @(negedge clk);
    chk_outs("flush_hold_after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_hold_instret", instret_o, exp_cnt);

    // Reset while the stage is valid
    step();
    apply(alu_op(5'd15, 32'h66));
    step();
    apply(idle_in);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    @(negedge clk);
    chk_outs("rst_mid", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst_mid_instret", instret_o, 64'd0);
    step();

    // Random traffic against the behavioural model
    m_valid = 1'b0;
    m_inst  = '0;
    exp_cnt = 64'd0;
    for (int c = 0; c < 2000; c++) begin
      cur.valid = ($urandom_range(0, 9) < 7);
      cur.we    = ($urandom_range(0, 3) != 0);
      cur.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      cur.sel   = 2'($urandom_range(0, 3));
      cur.alu   = $urandom; cur.pc4 = $urandom; cur.csr = $urandom; cur.ld = $urandom;
      cur.f3    = 3'($urandom_range(0, 7));
      cur.lsb   = 2'($urandom_range(0, 3));
      cur.hold  = ($urandom_range(0, 4) == 0);
      cur.flush = ($urandom_range(0, 9) == 0);
      rst_cur   = ($urandom_range(0, 99) == 0);
      apply(cur);
      rst_ni = !rst_cur;
      @(negedge clk);
      m_ret = m_valid && !cur.hold;
      m_res = ref_result(m_inst);
      m_e   = m_ret && m_res[32];
      m_w   = m_ret && m_inst.we && (m_inst.rd != 5'd0) && !m_res[32];
      chk("rnd_ready", ready_o, !cur.hold);
      chk_outs("rnd", m_ret, m_w, m_w ? m_inst.rd : 5'd0, m_w ? m_res[31:0] : 32'd0, m_e);
      chk("rnd_instret", instret_o, exp_cnt);
      if (rst_cur) begin
        m_valid = 1'b0;
        exp_cnt = 64'd0;
      end else begin
        if (m_ret) exp_cnt++;
        if (cur.flush) begin
          m_valid = 1'b0;
        end else if (!cur.hold) begin
          m_valid = cur.valid;
          if (cur.valid) m_inst = cur;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
